// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arithmetic ops, a
// bit-serial shifter (SLL/SRA, one bit per cycle) and an unsigned
// shift-add multiplier (WIDTH iterations).
//
// Ports
//   clk_i                 clock, all state on the rising edge
//   rst_i                 synchronous active-high reset
//   start_i               request, accepted in IDLE or DONE only
//   op_i[3:0]             operation code
//   a_i, b_i [WIDTH-1:0]  operands
//   shamt_i [SHAMT_W-1:0] shift amount for SLL/SRA
//   busy_o                high while shifting or multiplying
//   done_o                one-cycle completion pulse
//   zero_o, overflow_o, carry_o, illegal_o   result flags
//   result_o [WIDTH-1:0]  final result, held until the next op completes
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | serial shift in progress, one bit per cycle
// MUL   | shift-add multiply in progress, one bit per cycle
// DONE  | result published, done pulse high
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               zero_o,
    output logic               overflow_o,
    output logic               carry_o,
    output logic               illegal_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SLT = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t               state_q;
    logic                 busy_q, done_q, zero_q, ovf_q, cry_q, ill_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     sh_q;
    logic                 sra_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH-1:0]     bop;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     sc_res_d;
    logic                 sc_ovf_d, sc_cry_d, sc_ill_d;
    logic [WIDTH-1:0]     shift_d;
    logic [WIDTH:0]       madd;
    logic [2*WIDTH-1:0]   mul_d;

    always_comb begin
        // SUB is A + ~B + 1; the same adder serves ADD with B and cin=0
        bop     = (op_i == OP_SUB) ? ~b_i : b_i;
        sum_ext = {1'b0, a_i} + {1'b0, bop} + {{WIDTH{1'b0}}, (op_i == OP_SUB)};

        sc_res_d = '0;
        sc_ovf_d = 1'b0;
        sc_cry_d = 1'b0;
        sc_ill_d = 1'b0;
        case (op_i)
            OP_AND: sc_res_d = a_i & b_i;
            OP_OR:  sc_res_d = a_i | b_i;
            OP_XOR: sc_res_d = a_i ^ b_i;
            OP_SLT: sc_res_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_ADD, OP_SUB: begin
                sc_res_d = sum_ext[WIDTH-1:0];
                sc_cry_d = sum_ext[WIDTH];
                // carry into the MSB recovered from the MSB sum bit
                sc_ovf_d = (a_i[WIDTH-1] ^ bop[WIDTH-1] ^ sum_ext[WIDTH-1]) ^ sum_ext[WIDTH];
            end
            default: sc_ill_d = 1'b1;
        endcase

        // SRA: MSB stays put, so replicating it each step keeps the captured sign
        shift_d = sra_q ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};

        // upper half accumulates, lower half holds the remaining multiplier bits
        madd  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_d = {madd, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cry_q    <= 1'b0;
            ill_q    <= 1'b0;
            result_q <= '0;
            sh_q     <= '0;
            sra_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        sra_q <= (op_i == OP_SRA);
                        if (op_i == OP_SLL || op_i == OP_SRA) begin
                            if (shamt_i == '0) begin
                                result_q <= a_i;
                                zero_q   <= (a_i == '0);
                                ovf_q    <= 1'b0;
                                cry_q    <= 1'b0;
                                ill_q    <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                sh_q    <= a_i;
                                cnt_q   <= {1'b0, shamt_i};
                                busy_q  <= 1'b1;
                                state_q <= SHIFT;
                            end
                        end else if (op_i == OP_MUL) begin
                            prod_q  <= {{WIDTH{1'b0}}, a_i};
                            mcand_q <= b_i;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= MUL;
                        end else begin
                            result_q <= sc_res_d;
                            zero_q   <= (sc_res_d == '0);
                            ovf_q    <= sc_ovf_d;
                            cry_q    <= sc_cry_d;
                            ill_q    <= sc_ill_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    sh_q  <= shift_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= shift_d;
                        zero_q   <= (shift_d == '0);
                        ovf_q    <= 1'b0;
                        cry_q    <= 1'b0;
                        ill_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                MUL: begin
                    prod_q <= mul_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= mul_d[WIDTH-1:0];
                        zero_q   <= (mul_d[WIDTH-1:0] == '0);
                        ovf_q    <= |mul_d[2*WIDTH-1:WIDTH];
                        cry_q    <= 1'b0;
                        ill_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign carry_o    = cry_q;
    assign illegal_o  = ill_q;
    assign result_o   = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16). Outputs are packed as
// {busy,done,zero,ovf,carry,illegal,result[15:0]} and compared against
// hand-computed constants, sampled 1 time unit after each rising edge.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  shamt;
    logic        busy, done, zero, ovf, cry, ill;
    logic [15:0] res;
    logic [21:0] obs;

    int vecs = 0;
    int errs = 0;

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .shamt_i(shamt),
        .busy_o(busy), .done_o(done), .zero_o(zero), .overflow_o(ovf),
        .carry_o(cry), .illegal_o(ill), .result_o(res)
    );

    always #5 clk = ~clk;
    assign obs = {busy, done, zero, ovf, cry, ill, res};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a one-cycle start; returns 1 time unit after the accepting edge
    task automatic go(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic [3:0] s);
        op = o; a = x; b = y; shamt = s; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 4'b0100; a = 16'h0001; b = 16'h0001; shamt = '0;
        step();
        step();
        vecs++;
        if (obs !== 22'h0) begin errs++; $display("FAIL reset_outputs got %h exp %h", obs, 22'h0); end
        start = 1'b0; rst = 1'b0;
        step();
        vecs++;
        if (obs !== 22'h0) begin errs++; $display("FAIL reset_no_accept got %h exp %h", obs, 22'h0); end
    endtask

    task automatic test_add();
        go(4'b0100, 16'h7FFF, 16'h0001, '0);
        vecs++;
        if (obs !== {6'b010100, 16'h8000}) begin errs++; $display("FAIL add_ovf got %h exp %h", obs, {6'b010100, 16'h8000}); end
        step();
        vecs++;
        if (obs !== {6'b000100, 16'h8000}) begin errs++; $display("FAIL add_hold got %h exp %h", obs, {6'b000100, 16'h8000}); end
        go(4'b0100, 16'hFFFF, 16'h0003, '0);
        vecs++;
        if (obs !== {6'b010010, 16'h0002}) begin errs++; $display("FAIL add_carry got %h exp %h", obs, {6'b010010, 16'h0002}); end
    endtask

    task automatic test_sub_slt_logic();
        go(4'b1100, 16'h0005, 16'h0005, '0);
        vecs++;
        if (obs !== {6'b011010, 16'h0000}) begin errs++; $display("FAIL sub_zero got %h exp %h", obs, {6'b011010, 16'h0000}); end
        go(4'b1100, 16'h8000, 16'h0001, '0);
        vecs++;
        if (obs !== {6'b010110, 16'h7FFF}) begin errs++; $display("FAIL sub_ovf got %h exp %h", obs, {6'b010110, 16'h7FFF}); end
        go(4'b0001, 16'hFFFF, 16'h0001, '0);
        vecs++;
        if (obs !== {6'b010000, 16'h0001}) begin errs++; $display("FAIL slt_neg got %h exp %h", obs, {6'b010000, 16'h0001}); end
        go(4'b0001, 16'h7FFF, 16'h8000, '0);
        vecs++;
        if (obs !== {6'b011000, 16'h0000}) begin errs++; $display("FAIL slt_ovf_false got %h exp %h", obs, {6'b011000, 16'h0000}); end
        go(4'b0001, 16'h8000, 16'h7FFF, '0);
        vecs++;
        if (obs !== {6'b010000, 16'h0001}) begin errs++; $display("FAIL slt_ovf_true got %h exp %h", obs, {6'b010000, 16'h0001}); end
        go(4'b0000, 16'hF0F0, 16'h3C3C, '0);
        vecs++;
        if (obs !== {6'b010000, 16'h3030}) begin errs++; $display("FAIL and got %h exp %h", obs, {6'b010000, 16'h3030}); end
        go(4'b0010, 16'hF0F0, 16'h3C3C, '0);
        vecs++;
        if (obs !== {6'b010000, 16'hFCFC}) begin errs++; $display("FAIL or got %h exp %h", obs, {6'b010000, 16'hFCFC}); end
        go(4'b0011, 16'hF0F0, 16'h3C3C, '0);
        vecs++;
        if (obs !== {6'b010000, 16'hCCCC}) begin errs++; $display("FAIL xor got %h exp %h", obs, {6'b010000, 16'hCCCC}); end
    endtask

    task automatic test_shift();
        int n;
        // previous result 0xCCCC must stay visible while busy
        go(4'b0111, 16'h8010, 16'h0000, 4'd4);
        a = 16'h0000; op = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (obs !== {6'b100000, 16'hCCCC}) begin errs++; $display("FAIL sra_busy%0d got %h exp %h", i, obs, {6'b100000, 16'hCCCC}); end
            if (i == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        vecs++;
        if (obs !== {6'b010000, 16'hF801}) begin errs++; $display("FAIL sra_done got %h exp %h", obs, {6'b010000, 16'hF801}); end
        step();
        vecs++;
        if (obs !== {6'b000000, 16'hF801}) begin errs++; $display("FAIL sra_pulse got %h exp %h", obs, {6'b000000, 16'hF801}); end

        go(4'b0110, 16'h0003, 16'h0000, 4'd15);
        n = 1;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        vecs++;
        if (n !== 16) begin errs++; $display("FAIL sll15_latency got %0d exp %0d", n, 16); end
        vecs++;
        if (obs !== {6'b010000, 16'h8000}) begin errs++; $display("FAIL sll15 got %h exp %h", obs, {6'b010000, 16'h8000}); end

        go(4'b0110, 16'h1234, 16'h0000, 4'd0);
        vecs++;
        if (obs !== {6'b010000, 16'h1234}) begin errs++; $display("FAIL sll0 got %h exp %h", obs, {6'b010000, 16'h1234}); end
    endtask

    task automatic test_mul();
        int n;
        go(4'b1000, 16'h0012, 16'h0034, '0);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) begin vecs++; errs++; $display("FAIL mul_busy got %b exp %b", busy, 1'b1); end
            step(); n++;
        end
        vecs++;
        if (n !== 17) begin errs++; $display("FAIL mul_latency got %0d exp %0d", n, 17); end
        vecs++;
        if (obs !== {6'b010000, 16'h03A8}) begin errs++; $display("FAIL mul_small got %h exp %h", obs, {6'b010000, 16'h03A8}); end

        go(4'b1000, 16'h0100, 16'h0100, '0);
        for (int i = 0; i < 16; i++) step();
        vecs++;
        if (obs !== {6'b011100, 16'h0000}) begin errs++; $display("FAIL mul_ovf_zero got %h exp %h", obs, {6'b011100, 16'h0000}); end

        go(4'b1000, 16'hFFFF, 16'hFFFF, '0);
        for (int i = 0; i < 16; i++) step();
        vecs++;
        if (obs !== {6'b010100, 16'h0001}) begin errs++; $display("FAIL mul_max got %h exp %h", obs, {6'b010100, 16'h0001}); end
        step();
        vecs++;
        if (obs !== {6'b000100, 16'h0001}) begin errs++; $display("FAIL mul_pulse got %h exp %h", obs, {6'b000100, 16'h0001}); end
    endtask

    task automatic test_reset_abort();
        int seen;
        go(4'b1000, 16'h0012, 16'h0034, '0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (obs !== 22'h0) begin errs++; $display("FAIL abort_outputs got %h exp %h", obs, 22'h0); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin step(); if (done === 1'b1 || busy === 1'b1) seen++; end
        vecs++;
        if (seen !== 0) begin errs++; $display("FAIL abort_no_done got %0d exp %0d", seen, 0); end
        go(4'b1111, 16'h1234, 16'h5678, '0);
        vecs++;
        if (obs !== {6'b011001, 16'h0000}) begin errs++; $display("FAIL illegal got %h exp %h", obs, {6'b011001, 16'h0000}); end
    endtask

    task automatic test_back_to_back();
        op = 4'b0100; a = 16'h0003; b = 16'h0005; start = 1'b1;
        step();
        vecs++;
        if (obs !== {6'b010000, 16'h0008}) begin errs++; $display("FAIL b2b_add got %h exp %h", obs, {6'b010000, 16'h0008}); end
        op = 4'b0011; a = 16'h00FF; b = 16'h0F0F;
        step();
        start = 1'b0;
        vecs++;
        if (obs !== {6'b010000, 16'h0FF0}) begin errs++; $display("FAIL b2b_xor got %h exp %h", obs, {6'b010000, 16'h0FF0}); end
        step();
        vecs++;
        if (obs !== {6'b000000, 16'h0FF0}) begin errs++; $display("FAIL b2b_idle got %h exp %h", obs, {6'b000000, 16'h0FF0}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt_logic();
        test_shift();
        test_mul();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (≥4, power of two).
REQ-002 Parameter SHAMT_W, default 4, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request; sampled on rising edge when accept-able (REQ-012).
REQ-006 Op  input  4  operation code (REQ-014).
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Shamt  input  SHAMT_W  shift amount for SLL/SRA.
REQ-010 Busy, Done, Zero, Overflow, CarryOut, Illegal  output  1 each; Result  output  WIDTH; all registered.

Function
REQ-011 States IDLE, SHIFT, MUL, DONE; reset state IDLE.
REQ-012 Start accepted only in IDLE or DONE; Start in SHIFT/MUL ignored, no effect on operation in flight.
REQ-013 On accept: A, B, Op, Shamt captured; later input changes do not affect the operation.
REQ-014 Op codes: 0000 AND, 0001 SLT, 0010 OR, 0011 XOR, 0100 ADD, 1100 SUB, 0110 SLL, 0111 SRA, 1000 MUL; all others illegal.
REQ-015 Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT, illegal): IDLE/DONE -> DONE; Done high in the cycle after accept.
REQ-016 SLL/SRA: Shamt=0 -> DONE directly (Result=A); else -> SHIFT, one bit per cycle, Shamt iterations, then DONE; Done asserts Shamt+1 cycles after accept.
REQ-017 SRA replicates captured A[WIDTH-1]; SLL fills with 0.
REQ-018 MUL: -> MUL, unsigned shift-add, exactly WIDTH iterations, then DONE; Done asserts WIDTH+1 cycles after accept.
REQ-019 MUL Result = low WIDTH bits of A*B; Overflow=1 iff upper WIDTH bits of full product nonzero; CarryOut=0.
REQ-020 ADD: Result=A+B mod 2^WIDTH; SUB: Result=A+~B+1; CarryOut = carry out of MSB; Overflow = carry into MSB XOR carry out of MSB.
REQ-021 SLT: Result=1 iff A<B as signed two's complement, correct even when A-B overflows; else 0; Overflow=CarryOut=0.
REQ-022 AND/OR/XOR/SLL/SRA/illegal: Overflow=CarryOut=0.
REQ-023 Illegal op: Result=0, Illegal=1, Done after one cycle; Illegal=0 for legal ops.
REQ-024 Zero = (Result==0), valid whenever Done=1, for every op.
REQ-025 Busy=1 exactly in SHIFT and MUL; 0 in IDLE and DONE.
REQ-026 Done is a one-cycle pulse; DONE -> IDLE next cycle unless Start accepted (back-to-back allowed).
REQ-027 Result and flags hold their final values after Done until the next accepted op completes; intermediate values never visible on Result.

Reset
REQ-028 Reset=1 at a rising edge: state IDLE; Busy, Done, Zero, Overflow, CarryOut, Illegal = 0; Result = 0.
REQ-029 Reset overrides Start in the same cycle; no operation accepted.
REQ-030 Reset during SHIFT/MUL aborts; no Done for aborted op; first op after reset behaves per REQ-015..018.

Verification (WIDTH=16)
REQ-031 ADD A=0x7FFF B=0x0001 -> next cycle Done=1, Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
REQ-032 SUB A=0x0005 B=0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0; SLT A=0xFFFF B=0x0001 -> Result=0x0001.
REQ-033 SRA A=0x8010 Shamt=4 -> Busy for 4 cycles, Done 5 cycles after accept, Result=0xF801; Start pulsed while Busy ignored.
REQ-034 MUL A=0x0012 B=0x0034 -> Done 17 cycles after accept, Result=0x03A8, Overflow=0; MUL 0x0100*0x0100 -> Result=0x0000, Zero=1, Overflow=1.
REQ-035 MUL started, Reset at 5th Busy cycle -> all outputs 0, no Done; then Op=1111 -> Done next cycle, Illegal=1, Result=0.
REQ-036 Back-to-back: Start held with ADD then XOR, Start re-asserted in Done cycle -> second Done exactly one cycle after first, Result reflects XOR.
